// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer and EX-stage target adder.
package pc_sequencer_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned BUB_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REDIR = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

endpackage

// File: rtl/branch_target_add.sv
// Branch target adder: base + (word offset << 2), modulo 2^32. Shared with the EX stage.
module branch_target_add
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] target_o
);

  // Offset bits above XLEN-WORD_SHIFT fall off the top of the shift.
  assign target_o = base_i + (offset_i << WORD_SHIFT);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and sequencer: sequential fetch, branch redirect with bubbles,
// sticky misaligned-target trap. Optional BRANCH_STATS_EN adds redirect/bubble counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_ready,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        trap
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_taken_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [BUB_W-1:0] BUB_INIT =
    BUB_W'((REDIRECT_BUBBLES == 0) ? 0 : REDIRECT_BUBBLES - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [BUB_W-1:0]  bub_q, bub_d;
  logic [XLEN-1:0]   target_c;
  logic              taken_c;

  branch_target_add u_target (
    .base_i   (br_pc),
    .offset_i (br_offset),
    .target_o (target_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bub_q   <= bub_d;
    end
  end

  // Next-state: taken beats stall beats sequential accept while fetching.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bub_d   = bub_q;
    taken_c = br_valid & br_taken & (state_q == ST_FETCH);
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (taken_c) begin
          pc_d = target_c;
          if (target_c[WORD_SHIFT-1:0] != '0) begin
            state_d = ST_TRAP;
          end else if (REDIRECT_BUBBLES != 0) begin
            state_d = ST_REDIR;
            bub_d   = BUB_INIT;
          end
        end else if (!stall && if_ready) begin
          pc_d = pc_q + XLEN'(PC_STEP);
        end
      end
      ST_REDIR: begin
        if (bub_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          bub_d = bub_q - 1'b1;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc       = pc_q;
  assign pc_valid = (state_q == ST_FETCH);
  assign trap     = (state_q == ST_TRAP);
  assign flush_if = taken_c;
  assign flush_id = taken_c;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, bubble_cnt_q;

  // Saturating event counters for taken redirects and redirect bubble cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (taken_c && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
      if ((state_q == ST_REDIR) && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign br_taken_cnt = taken_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (1 and 3 redirect bubbles) driven by shared stimulus.
module tb_pc_sequencer;

  logic        clk, rst_n, stall, if_ready, br_valid, br_taken;
  logic [31:0] br_pc, br_offset;
  logic [31:0] pc_a, pc_b;
  logic        pv_a, pv_b, fi_a, fi_b, fd_a, fd_b, tr_a, tr_b;
`ifdef BRANCH_STATS_EN
  logic [31:0] tc_a, tc_b, bc_a, bc_b;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state per instance: index 0 -> 1 bubble, index 1 -> 3 bubbles
  logic [31:0] m_pc   [2];
  bit          m_idle [2];
  bit          m_trap [2];
  int          m_bub  [2];
  int unsigned m_tcnt [2];
  int unsigned m_bcnt [2];

  pc_sequencer #(.RESET_PC(32'h0), .REDIRECT_BUBBLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_ready(if_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .pc(pc_a), .pc_valid(pv_a), .flush_if(fi_a), .flush_id(fd_a), .trap(tr_a)
`ifdef BRANCH_STATS_EN
    , .br_taken_cnt(tc_a), .bubble_cnt(bc_a)
`endif
  );

  pc_sequencer #(.RESET_PC(32'h0), .REDIRECT_BUBBLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_ready(if_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .pc(pc_b), .pc_valid(pv_b), .flush_if(fi_b), .flush_id(fd_b), .trap(tr_b)
`ifdef BRANCH_STATS_EN
    , .br_taken_cnt(tc_b), .bubble_cnt(bc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bubs(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit m_valid(int k);
    return !m_idle[k] && (m_bub[k] == 0) && !m_trap[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_idle[k] = 1'b1; m_trap[k] = 1'b0; m_bub[k] = 0;
      m_tcnt[k] = 0; m_bcnt[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] tgt;
      bit tk;
      tk  = br_valid && br_taken && m_valid(k);
      tgt = br_pc + br_offset * 32'd4;
      if (m_bub[k] > 0 && m_bcnt[k] != 32'hFFFF_FFFF) m_bcnt[k]++;
      if (tk && m_tcnt[k] != 32'hFFFF_FFFF) m_tcnt[k]++;
      if (m_idle[k]) begin
        m_idle[k] = 1'b0;
      end else if (!m_trap[k]) begin
        if (m_bub[k] > 0) begin
          m_bub[k]--;
        end else if (tk) begin
          m_pc[k] = tgt;
          if (tgt % 4 != 0) m_trap[k] = 1'b1;
          else m_bub[k] = bubs(k);
        end else if (!stall && if_ready) begin
          m_pc[k] = m_pc[k] + 32'd4;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(bit v, bit t, logic [31:0] bp, logic [31:0] off, bit st, bit rdy);
    br_valid = v; br_taken = t; br_pc = bp; br_offset = off; stall = st; if_ready = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", pc_a); end
    checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL reset_pc_valid got %b exp 0", pv_a); end
    checks++; if (tr_a !== 1'b0 || tr_b !== 1'b0) begin errors++; $display("FAIL reset_trap got %b%b exp 00", tr_a, tr_b); end
    checks++; if ({fi_a, fd_a} !== 2'b00) begin errors++; $display("FAIL reset_flush got %b%b exp 00", fi_a, fd_a); end
  endtask

  task automatic test_sequential();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL idle_cycle pc_valid got %b exp 0", pv_a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_a !== 32'(i * 4) || pv_a !== 1'b1) begin
        errors++; $display("FAIL seq_fetch[%0d] got pc=%h v=%b exp pc=%h v=1", i, pc_a, pv_a, 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (pc_a !== 32'h10) begin errors++; $display("FAIL redir_setup got %h exp 00000010", pc_a); end
    drive(1, 1, 32'h0C, 32'h4, 0, 1);
    #1;
    checks++; if ({fi_a, fd_a} !== 2'b11) begin errors++; $display("FAIL redir_flush got %b%b exp 11", fi_a, fd_a); end
    tick();
    // Branch inputs still asserted during the bubble must be ignored.
    #1;
    checks++; if ({fi_a, fd_a} !== 2'b00) begin errors++; $display("FAIL redir_flush_one_cycle got %b%b exp 00", fi_a, fd_a); end
    checks++; if (pc_a !== 32'h1C || pv_a !== 1'b0) begin errors++; $display("FAIL redir_bubble got pc=%h v=%b exp pc=0000001c v=0", pc_a, pv_a); end
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    checks++; if (pc_a !== 32'h1C || pv_a !== 1'b1) begin errors++; $display("FAIL redir_resume got pc=%h v=%b exp pc=0000001c v=1", pc_a, pv_a); end
    tick();
    checks++; if (pc_a !== 32'h20) begin errors++; $display("FAIL redir_advance got %h exp 00000020", pc_a); end
  endtask

  task automatic test_stall_priority();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) tick();
    drive(1, 1, 32'h40, 32'h1, 1, 1);
    #1;
    checks++; if (fi_a !== 1'b1) begin errors++; $display("FAIL stall_taken_flush got %b exp 1", fi_a); end
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    checks++; if (pc_a !== 32'h44) begin errors++; $display("FAIL stall_taken_pc got %h exp 00000044", pc_a); end
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_a !== 32'h44 || pv_a !== 1'b1 || fi_a !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got pc=%h v=%b f=%b exp pc=00000044 v=1 f=0", i, pc_a, pv_a, fi_a);
      end
    end
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    tick();
    checks++; if (pc_a !== 32'h48) begin errors++; $display("FAIL stall_release got %h exp 00000048", pc_a); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    tick();
    drive(1, 1, 32'hFFFF_FFF0, 32'h8, 0, 1);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    checks++; if (pc_a !== 32'h10) begin errors++; $display("FAIL target_wrap got %h exp 00000010", pc_a); end
    tick();
    drive(1, 1, 32'h0, 32'h3FFF_FFFF, 0, 1);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    tick();
    checks++; if (pc_a !== 32'hFFFF_FFFC || pv_a !== 1'b1) begin errors++; $display("FAIL top_fetch got pc=%h v=%b exp pc=fffffffc v=1", pc_a, pv_a); end
    tick();
    checks++; if (pc_a !== 32'h0 || tr_a !== 1'b0) begin errors++; $display("FAIL seq_wrap got pc=%h t=%b exp pc=00000000 t=0", pc_a, tr_a); end
  endtask

  task automatic test_not_taken_and_trap();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    tick(); tick();
    drive(1, 0, 32'h100, 32'h5, 0, 1);
    #1;
    checks++; if (fi_a !== 1'b0) begin errors++; $display("FAIL not_taken_flush got %b exp 0", fi_a); end
    tick();
    checks++; if (pc_a !== 32'h8) begin errors++; $display("FAIL not_taken_pc got %h exp 00000008", pc_a); end
    drive(1, 1, 32'h2, 32'h1, 0, 1);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tr_a !== 1'b1 || pv_a !== 1'b0 || pc_a !== 32'h6) begin
        errors++; $display("FAIL trap_sticky[%0d] got t=%b v=%b pc=%h exp t=1 v=0 pc=00000006", i, tr_a, pv_a, pc_a);
      end
      tick();
    end
    do_reset();
    checks++; if (tr_a !== 1'b0 || pc_a !== 32'h0) begin errors++; $display("FAIL trap_clear got t=%b pc=%h exp t=0 pc=00000000", tr_a, pc_a); end
  endtask

  task automatic test_async_reset_redir();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    tick();
    drive(1, 1, 32'h1C, 32'h1, 0, 1);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    tick();
    checks++; if (pv_b !== 1'b0 || pc_b !== 32'h20) begin errors++; $display("FAIL redir3_mid got v=%b pc=%h exp v=0 pc=00000020", pv_b, pc_b); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc_b !== 32'h0 || pv_b !== 1'b0 || tr_b !== 1'b0 || fi_b !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h v=%b t=%b f=%b exp pc=00000000 v=0 t=0 f=0", pc_b, pv_b, tr_b, fi_b);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef BRANCH_STATS_EN
    checks++; if (tc_b !== 32'd0 || bc_b !== 32'd0) begin errors++; $display("FAIL stats_reset got tc=%0d bc=%0d exp 0 0", tc_b, bc_b); end
`endif
    tick();
    drive(1, 1, 32'h1C, 32'h1, 0, 1);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pv_b !== 1'b1 || pc_b !== 32'h20) begin errors++; $display("FAIL redir3_resume got v=%b pc=%h exp v=1 pc=00000020", pv_b, pc_b); end
`ifdef BRANCH_STATS_EN
    checks++; if (tc_b !== 32'd1 || bc_b !== 32'd3) begin errors++; $display("FAIL stats_b got tc=%0d bc=%0d exp 1 3", tc_b, bc_b); end
    checks++; if (tc_a !== 32'd1 || bc_a !== 32'd1) begin errors++; $display("FAIL stats_a got tc=%0d bc=%0d exp 1 1", tc_a, bc_a); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] bp;
    logic [31:0] obs_pc [2];
    logic        obs_v [2], obs_t [2], obs_f [2];
    do_reset();
    for (int n = 0; n < 600; n++) begin
      obs_pc[0] = pc_a; obs_pc[1] = pc_b;
      obs_v[0] = pv_a;  obs_v[1] = pv_b;
      obs_t[0] = tr_a;  obs_t[1] = tr_b;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pc[k] !== m_pc[k] || obs_v[k] !== m_valid(k) || obs_t[k] !== m_trap[k]) begin
          errors++;
          $display("FAIL rand_state[%0d] inst=%0d got pc=%h v=%b t=%b exp pc=%h v=%b t=%b",
                   n, k, obs_pc[k], obs_v[k], obs_t[k], m_pc[k], m_valid(k), m_trap[k]);
        end
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (tc_a !== m_tcnt[0] || bc_a !== m_bcnt[0] || tc_b !== m_tcnt[1] || bc_b !== m_bcnt[1]) begin
        errors++;
        $display("FAIL rand_stats[%0d] got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", n,
                 tc_a, bc_a, tc_b, bc_b, m_tcnt[0], m_bcnt[0], m_tcnt[1], m_bcnt[1]);
      end
`endif
      if (m_trap[0] || m_trap[1]) do_reset();
      bp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(15) == 0) bp[1:0] = 2'($urandom);
      drive(($urandom_range(3) == 0), 1'($urandom), bp, $urandom,
            ($urandom_range(3) == 0), ($urandom_range(3) != 0));
      #1;
      obs_f[0] = fi_a & fd_a; obs_f[1] = fi_b & fd_b;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_f[k] !== (br_valid && br_taken && m_valid(k))) begin
          errors++;
          $display("FAIL rand_flush[%0d] inst=%0d got %b exp %b", n, k, obs_f[k], br_valid && br_taken && m_valid(k));
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_priority();
    test_wrap();
    test_not_taken_and_trap();
    test_async_reset_redir();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
